memory_writeback_stage: RTL and testbench
=========================================

// Module: memory_writeback_stage
// PURPOSE
//  Memory + writeback half of the 5-stage RV32I pipeline; the producer of the register-file write port (A3/WD3/WE3).
//  Issues loads/stores to a ready-handshaked data memory and stalls the pipe while an access is pending.
//  Registers M->W state, sign/zero-extends load data and selects the writeback result.
//  Counts retired instructions.
// PARAMETERS
//  D_WIDTH      32  datapath / address width
//  A_WIDTH      5   register address width
//  TIMEOUT_CYC  64  max wait cycles per access (used only with MEM_TIMEOUT_EN)
// PORTS
//  clk          in   1        rising-edge clock
//  rst_n        in   1        synchronous active-low reset
//  ValidM       in   1        M-stage slot holds a real instruction
//  RegWriteM    in   1        instruction writes rd
//  ResultSrcM   in   2        00 ALU, 01 load data, 10 PC+4
//  MemWriteM    in   1        store
//  Funct3M      in   3        load/store size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//  ALUResultM   in   D_WIDTH  effective address / ALU result
//  WriteDataM   in   D_WIDTH  store data (unaligned in low bits)
//  RdM          in   A_WIDTH  destination register
//  PCplus4M     in   D_WIDTH  link value
//  mem_req      out  1        access request
//  mem_we       out  1        1 store, 0 load
//  mem_addr     out  D_WIDTH  word-aligned address ({ALUResultM[D_WIDTH-1:2],2'b00})
//  mem_wdata    out  D_WIDTH  store data replicated to lanes
//  mem_be       out  4        byte enables
//  mem_rdata    in   D_WIDTH  load data, valid when mem_ready
//  mem_ready    in   1        access completes this cycle when mem_req && mem_ready
//  StallM       out  1        hold M-stage and upstream registers
//  mem_err      out  1        access aborted by timeout (MEM_TIMEOUT_EN only, else 0)
//  WE3          out  1        register-file write enable
//  A3           out  A_WIDTH  register-file write address
//  WD3          out  D_WIDTH  register-file write data
//  instret      out  32       retired-instruction count
// BEHAVIOUR
//  - access_m = ValidM & (MemWriteM | ResultSrcM==01); mem_req = access_m in IDLE and WAIT (combinational).
//  - Misaligned H/W accesses are not checked; byte lanes are taken from addr[1:0].
//  - FSM IDLE/WAIT. IDLE: access_m & ~mem_ready -> WAIT, StallM=1; access_m & mem_ready -> done, no stall.
//    WAIT: mem_req held, StallM=1 until mem_ready, then -> IDLE and the access completes.
//    A zero-wait memory (mem_ready tied 1) never stalls.
//  - Upstream holds all *M inputs stable while StallM=1; mem_addr/we/wdata/be are stable for the whole request.
//  - M->W register: on a non-stall cycle it captures ValidM, RegWriteM, ResultSrcM, RdM, ALUResultM, PCplus4M and extended load data.
//    On a stall cycle it captures a bubble (ValidW=0, RegWriteW=0).
//  - Load extend (from the W-registered copy of mem_rdata): B/H sign-extend, BU/HU zero-extend, W pass-through.
//  - WD3 = ResultSrcW 00 ALUResultW, 01 LoadDataW, 10 PCplus4W, 11 0.
//    A3 = RdW. WE3 = ValidW & RegWriteW & (RdW != 0).
//  - Latency: M inputs to WE3/A3/WD3 is 1 cycle after the access completes.
//  - instret increments by 1 each cycle ValidW=1 and wraps 0xFFFFFFFF -> 0.
//  - Reset: state IDLE; ValidW, RegWriteW, RdW, ResultSrcW, ALUResultW, LoadDataW, PCplus4W = 0; instret = 0.
//    Therefore WE3=0, A3=0, WD3=0 and StallM=0 out of reset.
//    Reset during WAIT returns to IDLE the next edge; mem_req then follows access_m.
// CONFIGURATION
//  MEM_TIMEOUT_EN defined: a wait counter runs in WAIT.
//    Reaching TIMEOUT_CYC forces a completion with load data 0, pulses mem_err for 1 cycle, and returns to IDLE.
//    The instruction still retires.
//  MEM_TIMEOUT_EN undefined: no counter; WAIT is unbounded; mem_err tied 0.
// STRUCTURE
//  pipeline_pkg: result_src_t (ALU/MEM/PC4), funct3 load/store size constants, mwb_state_t {IDLE, WAIT}.
//  Sub-module load_store_align: combinational byte-enable/lane-replicate for stores and extract/extend for loads.
// TESTING
//  1 ALU op: ValidM=1, RegWriteM=1, ResultSrcM=00, ALUResultM=0x1234, RdM=5 -> next cycle WE3=1, A3=5, WD3=0x1234, instret+1.
//  2 LB zero-wait: addr 0x103, mem_rdata=0x80FF_0000 -> WD3=0xFFFF_FF80; LBU -> 0x80; StallM never 1.
//  3 SW with 3 wait states: StallM=1 for 3 cycles, mem_* stable, mem_be=1111; no WE3; 3 bubbles with instret unchanged.
//  4 rd=x0 JAL (ResultSrcM=10) -> WE3=0 although RegWriteM=1; instret still increments.
//  5 rst_n low mid-WAIT -> next edge state IDLE, WE3=0, instret=0, StallM follows access_m.
//  6 MEM_TIMEOUT_EN, mem_ready held 0 -> after 64 cycles mem_err pulses 1 cycle, WD3=0, pipe resumes.

Source files
------------

// File: rtl/pipeline_pkg.sv
// Shared types for the memory/writeback half of the RV32I pipeline.
// Timeout support is enabled with MEM_TIMEOUT_EN.
package pipeline_pkg;

  typedef enum logic [1:0] {
    RES_ALU = 2'b00,
    RES_MEM = 2'b01,
    RES_PC4 = 2'b10
  } result_src_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef logic [0:0] mwb_state_t;

  localparam mwb_state_t S_IDLE = 1'b0;
  localparam mwb_state_t S_WAIT = 1'b1;

endpackage

// File: rtl/memory_writeback_stage_align.sv
// Byte-lane steering: store replicate/enables and load extract/extend.
// Purely combinational, shared by the M and W sides of the stage.
module load_store_align
  import pipeline_pkg::*;
#(
  parameter int D_WIDTH = 32
) (
  input  logic [2:0]         st_funct3,
  input  logic [1:0]         st_off,
  input  logic [D_WIDTH-1:0] st_data,
  output logic [D_WIDTH-1:0] st_wdata,
  output logic [3:0]         st_be,
  input  logic [2:0]         ld_funct3,
  input  logic [1:0]         ld_off,
  input  logic [D_WIDTH-1:0] ld_rdata,
  output logic [D_WIDTH-1:0] ld_data
);

  logic [D_WIDTH-1:0] shifted;

  always_comb begin
    st_wdata = st_data;
    st_be    = 4'b1111;
    case (st_funct3[1:0])
      2'b00: begin
        st_wdata = {(D_WIDTH/8){st_data[7:0]}};
        st_be    = 4'b0001 << st_off;
      end
      2'b01: begin
        st_wdata = {(D_WIDTH/16){st_data[15:0]}};
        st_be    = st_off[1] ? 4'b1100 : 4'b0011;
      end
      default: begin
        st_wdata = st_data;
        st_be    = 4'b1111;
      end
    endcase
  end

  // Lane select comes from the low address bits; misalignment is not trapped
  always_comb begin
    shifted = ld_rdata >> {ld_off, 3'b000};
    ld_data = ld_rdata;
    case (ld_funct3)
      F3_B:  ld_data = {{(D_WIDTH-8){shifted[7]}}, shifted[7:0]};
      F3_H:  ld_data = {{(D_WIDTH-16){shifted[15]}}, shifted[15:0]};
      F3_BU: ld_data = {{(D_WIDTH-8){1'b0}}, shifted[7:0]};
      F3_HU: ld_data = {{(D_WIDTH-16){1'b0}}, shifted[15:0]};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/memory_writeback_stage.sv
// Memory + writeback stage: data-memory handshake, M->W register, RF write port.
// Define MEM_TIMEOUT_EN to bound each access to TIMEOUT_CYC wait cycles.
module memory_writeback_stage
  import pipeline_pkg::*;
#(
  parameter int D_WIDTH     = 32,
  parameter int A_WIDTH     = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ValidM,
  input  logic               RegWriteM,
  input  logic [1:0]         ResultSrcM,
  input  logic               MemWriteM,
  input  logic [2:0]         Funct3M,
  input  logic [D_WIDTH-1:0] ALUResultM,
  input  logic [D_WIDTH-1:0] WriteDataM,
  input  logic [A_WIDTH-1:0] RdM,
  input  logic [D_WIDTH-1:0] PCplus4M,
  output logic               mem_req,
  output logic               mem_we,
  output logic [D_WIDTH-1:0] mem_addr,
  output logic [D_WIDTH-1:0] mem_wdata,
  output logic [3:0]         mem_be,
  input  logic [D_WIDTH-1:0] mem_rdata,
  input  logic               mem_ready,
  output logic               StallM,
  output logic               mem_err,
  output logic               WE3,
  output logic [A_WIDTH-1:0] A3,
  output logic [D_WIDTH-1:0] WD3,
  output logic [31:0]        instret
);

  mwb_state_t state_q, state_d;

  logic access_m;
  logic done_m;
  logic timeout_m;

  logic               valid_w_q, valid_w_d;
  logic               regwrite_w_q, regwrite_w_d;
  logic [1:0]         result_src_w_q, result_src_w_d;
  logic [A_WIDTH-1:0] rd_w_q, rd_w_d;
  logic [D_WIDTH-1:0] alu_w_q, alu_w_d;
  logic [D_WIDTH-1:0] pc4_w_q, pc4_w_d;
  logic [D_WIDTH-1:0] load_data_w_q, load_data_w_d;
  logic [2:0]         funct3_w_q, funct3_w_d;
  logic [31:0]        instret_q, instret_d;
  logic [D_WIDTH-1:0] ld_ext_w;

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYC + 1);

  logic [CW-1:0] wait_cnt_q, wait_cnt_d;

  always_comb begin
    timeout_m = (state_q == S_WAIT)
              && (wait_cnt_q == CW'(TIMEOUT_CYC - 1))
              && !mem_ready;
    wait_cnt_d = '0;
    if (state_q == S_WAIT && StallM)
      wait_cnt_d = wait_cnt_q + 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) wait_cnt_q <= '0;
    else        wait_cnt_q <= wait_cnt_d;
  end

  assign mem_err = timeout_m & access_m;
`else
  assign timeout_m = 1'b0;
  assign mem_err   = 1'b0;
`endif

  load_store_align #(
    .D_WIDTH (D_WIDTH)
  ) u_align (
    .st_funct3 (Funct3M),
    .st_off    (ALUResultM[1:0]),
    .st_data   (WriteDataM),
    .st_wdata  (mem_wdata),
    .st_be     (mem_be),
    .ld_funct3 (funct3_w_q),
    .ld_off    (alu_w_q[1:0]),
    .ld_rdata  (load_data_w_q),
    .ld_data   (ld_ext_w)
  );

  always_comb begin
    access_m = ValidM & (MemWriteM | (ResultSrcM == RES_MEM));
    done_m   = access_m & (mem_ready | timeout_m);
    StallM   = access_m & ~done_m;
    state_d  = StallM ? S_WAIT : S_IDLE;

    mem_req  = access_m;
    mem_we   = MemWriteM;
    mem_addr = {ALUResultM[D_WIDTH-1:2], 2'b00};

    // A stalled slot enters W as a bubble; payload fields are don't-care
    valid_w_d      = ValidM & ~StallM;
    regwrite_w_d   = RegWriteM & ~StallM;
    result_src_w_d = ResultSrcM;
    rd_w_d         = RdM;
    alu_w_d        = ALUResultM;
    pc4_w_d        = PCplus4M;
    funct3_w_d     = Funct3M;
    load_data_w_d  = mem_ready ? mem_rdata : '0;

    instret_d = instret_q + {31'b0, valid_w_q};
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      valid_w_q      <= 1'b0;
      regwrite_w_q   <= 1'b0;
      result_src_w_q <= 2'b00;
      rd_w_q         <= '0;
      alu_w_q        <= '0;
      pc4_w_q        <= '0;
      load_data_w_q  <= '0;
      funct3_w_q     <= 3'b000;
      instret_q      <= '0;
    end else begin
      state_q        <= state_d;
      valid_w_q      <= valid_w_d;
      regwrite_w_q   <= regwrite_w_d;
      result_src_w_q <= result_src_w_d;
      rd_w_q         <= rd_w_d;
      alu_w_q        <= alu_w_d;
      pc4_w_q        <= pc4_w_d;
      load_data_w_q  <= load_data_w_d;
      funct3_w_q     <= funct3_w_d;
      instret_q      <= instret_d;
    end
  end

  always_comb begin
    WE3 = valid_w_q & regwrite_w_q & (rd_w_q != '0);
    A3  = rd_w_q;
    case (result_src_w_q)
      RES_ALU: WD3 = alu_w_q;
      RES_MEM: WD3 = ld_ext_w;
      RES_PC4: WD3 = pc4_w_q;
      default: WD3 = '0;
    endcase
    instret = instret_q;
  end

endmodule

// File: tb/tb_memory_writeback_stage.sv
// Directed + randomized bench for memory_writeback_stage.
// Honours MEM_TIMEOUT_EN for the timeout scenario.
module tb_memory_writeback_stage;
  import pipeline_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        ValidM, RegWriteM, MemWriteM;
  logic [1:0]  ResultSrcM;
  logic [2:0]  Funct3M;
  logic [31:0] ALUResultM, WriteDataM, PCplus4M;
  logic [4:0]  RdM;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [3:0]  mem_be;
  logic [31:0] mem_rdata;
  logic        mem_ready;
  logic        StallM, mem_err, WE3;
  logic [4:0]  A3;
  logic [31:0] WD3, instret;

  int errors = 0;
  int checks = 0;

  bit          pend_valid;
  bit          pend_we;
  logic [4:0]  pend_a3;
  logic [31:0] pend_wd;
  logic [31:0] exp_instret;

  bit          cur_access;
  logic [31:0] cur_ld;

  always #5 clk = ~clk;

  memory_writeback_stage dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .ValidM     (ValidM),
    .RegWriteM  (RegWriteM),
    .ResultSrcM (ResultSrcM),
    .MemWriteM  (MemWriteM),
    .Funct3M    (Funct3M),
    .ALUResultM (ALUResultM),
    .WriteDataM (WriteDataM),
    .RdM        (RdM),
    .PCplus4M   (PCplus4M),
    .mem_req    (mem_req),
    .mem_we     (mem_we),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_be     (mem_be),
    .mem_rdata  (mem_rdata),
    .mem_ready  (mem_ready),
    .StallM     (StallM),
    .mem_err    (mem_err),
    .WE3        (WE3),
    .A3         (A3),
    .WD3        (WD3),
    .instret    (instret)
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference load result from the byte/halfword arithmetic of RV32I
  function automatic logic [31:0] ld_model(input logic [2:0] f3,
      input logic [1:0] off, input logic [31:0] w);
    int unsigned b, h;
    b = (w >> (8 * off)) & 32'hFF;
    h = (w >> (8 * off)) & 32'hFFFF;
    case (f3)
      3'b000:  return (b >= 128) ? (b | 32'hFFFF_FF00) : b;
      3'b001:  return (h >= 32768) ? (h | 32'hFFFF_0000) : h;
      3'b100:  return b;
      3'b101:  return h;
      default: return w;
    endcase
  endfunction

  function automatic logic [3:0] be_model(input logic [2:0] f3,
                                          input logic [1:0] off);
    case (f3[1:0])
      2'b00:   return 4'(1 << off);
      2'b01:   return 4'(3 << (2 * (off / 2)));
      default: return 4'hF;
    endcase
  endfunction

  function automatic logic [31:0] wd_model(input logic [2:0] f3,
                                           input logic [31:0] d);
    case (f3[1:0])
      2'b00:   return (d & 32'hFF) * 32'h0101_0101;
      2'b01:   return (d & 32'hFFFF) * 32'h0001_0001;
      default: return d;
    endcase
  endfunction

  task automatic cycle(input bit exp_stall, input bit exp_err);
    @(negedge clk);
    chk("we3", {31'b0, WE3}, {31'b0, pend_we});
    if (pend_valid) begin
      chk("a3", {27'b0, A3}, {27'b0, pend_a3});
      chk("wd3", WD3, pend_wd);
    end
    chk("instret", instret, exp_instret);
    chk("stallm", {31'b0, StallM}, {31'b0, exp_stall});
    chk("mem_err", {31'b0, mem_err}, {31'b0, exp_err});
    chk("mem_req", {31'b0, mem_req}, {31'b0, cur_access});
    if (cur_access) begin
      chk("mem_addr", mem_addr, ALUResultM & 32'hFFFF_FFFC);
      chk("mem_we", {31'b0, mem_we}, {31'b0, MemWriteM});
      if (MemWriteM) begin
        chk("mem_be", {28'b0, mem_be},
            {28'b0, be_model(Funct3M, ALUResultM[1:0])});
        chk("mem_wdata", mem_wdata, wd_model(Funct3M, WriteDataM));
      end
    end
    if (pend_valid) exp_instret = exp_instret + 1;
    pend_valid = ValidM && !exp_stall;
    pend_we    = pend_valid && RegWriteM && (RdM != 0);
    pend_a3    = RdM;
    case (ResultSrcM)
      2'b00:   pend_wd = ALUResultM;
      2'b01:   pend_wd = ld_model(Funct3M, ALUResultM[1:0], cur_ld);
      2'b10:   pend_wd = PCplus4M;
      default: pend_wd = 32'h0;
    endcase
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input bit v, input bit rw, input logic [1:0] rs,
      input bit mw, input logic [2:0] f3, input logic [31:0] alu,
      input logic [31:0] wd, input logic [4:0] rd, input logic [31:0] pc4,
      input int waits, input logic [31:0] rdata);
    int stalls;
    bit to;
    ValidM     = v;
    RegWriteM  = rw;
    ResultSrcM = rs;
    MemWriteM  = mw;
    Funct3M    = f3;
    ALUResultM = alu;
    WriteDataM = wd;
    RdM        = rd;
    PCplus4M   = pc4;
    cur_access = v && (mw || rs == 2'b01);
    stalls     = cur_access ? waits : 0;
    to         = 1'b0;
`ifdef MEM_TIMEOUT_EN
    if (stalls >= 64) begin
      stalls = 64;
      to     = 1'b1;
    end
`endif
    cur_ld = to ? 32'h0 : rdata;
    for (int i = 0; i <= stalls; i++) begin
      mem_ready = (i == stalls) && !to;
      mem_rdata = (i == stalls) ? rdata : $urandom;
      cycle(cur_access && (i < stalls), to && (i == stalls));
    end
  endtask

  task automatic idle();
    issue(0, 0, 2'b00, 0, F3_W, 32'h0, 32'h0, 5'd0, 32'h0, 0, 32'h0);
  endtask

  initial begin
    rst_n = 1'b0;
    ValidM = 0; RegWriteM = 0; ResultSrcM = 2'b00; MemWriteM = 0;
    Funct3M = 3'b010; ALUResultM = 0; WriteDataM = 0; RdM = 0;
    PCplus4M = 0; mem_rdata = 0; mem_ready = 1'b1;
    pend_valid = 0; pend_we = 0; pend_a3 = 0; pend_wd = 0;
    exp_instret = 0; cur_access = 0; cur_ld = 0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_we3", {31'b0, WE3}, 32'h0);
    chk("rst_a3", {27'b0, A3}, 32'h0);
    chk("rst_wd3", WD3, 32'h0);
    chk("rst_stall", {31'b0, StallM}, 32'h0);
    chk("rst_instret", instret, 32'h0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // ALU op retires one cycle later
    issue(1, 1, 2'b00, 0, F3_W, 32'h1234, 0, 5'd5, 32'h100, 0, 0);
    chk("alu_wd3_lit", WD3, 32'h1234);
    chk("alu_a3_lit", {27'b0, A3}, 32'd5);

    // LB / LBU zero-wait from lane 3
    issue(1, 1, 2'b01, 0, F3_B, 32'h103, 0, 5'd6, 32'h104, 0,
          32'h80FF_0000);
    chk("lb_wd3_lit", WD3, 32'hFFFF_FF80);
    issue(1, 1, 2'b01, 0, F3_BU, 32'h103, 0, 5'd7, 32'h108, 0,
          32'h80FF_0000);
    chk("lbu_wd3_lit", WD3, 32'h0000_0080);

    // SW with three wait states
    issue(1, 0, 2'b00, 1, F3_W, 32'h200, 32'hDEAD_BEEF, 5'd9, 32'h10C,
          3, 0);
    chk("sw_we3_lit", {31'b0, WE3}, 32'h0);

    // JAL to x0 retires without a register write
    issue(1, 1, 2'b10, 0, F3_W, 32'h300, 0, 5'd0, 32'h114, 0, 0);
    chk("jal_x0_we3", {31'b0, WE3}, 32'h0);
    idle();

    // Byte and halfword stores at the lane boundaries
    issue(1, 0, 2'b00, 1, F3_B, 32'h401, 32'h1234_56AB, 5'd1, 0, 1, 0);
    issue(1, 0, 2'b00, 1, F3_H, 32'h402, 32'h1234_CDEF, 5'd1, 0, 0, 0);
    issue(1, 1, 2'b01, 0, F3_H, 32'h402, 0, 5'd3, 0, 2, 32'h8001_7FFF);
    issue(1, 1, 2'b11, 0, F3_W, 32'h55, 0, 5'd4, 32'h66, 0, 0);

    // Reset while an access sits in WAIT
    issue(1, 1, 2'b01, 0, F3_W, 32'h40, 0, 5'd8, 0, 0, 32'h1111);
    ALUResultM = 32'h44;
    ResultSrcM = 2'b01;
    ValidM     = 1'b1;
    cur_access = 1'b1;
    mem_ready  = 1'b0;
    cycle(1, 0);
    cycle(1, 0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    chk("wrst_a3", {27'b0, A3}, 32'h0);
    chk("wrst_wd3", WD3, 32'h0);
    chk("wrst_instret", instret, 32'h0);
    pend_valid  = 0;
    pend_we     = 0;
    exp_instret = 0;
    cycle(1, 0);
    mem_rdata = 32'hCAFE_F00D;
    cur_ld    = 32'hCAFE_F00D;
    mem_ready = 1'b1;
    cycle(0, 0);
    idle();

    // Randomized instruction mix
    for (int n = 0; n < 60; n++) begin
      int unsigned kind;
      logic [2:0]  f3;
      logic [31:0] a;
      kind = $urandom_range(0, 4);
      case ($urandom_range(0, 4))
        0: f3 = F3_B;
        1: f3 = F3_H;
        2: f3 = F3_W;
        3: f3 = F3_BU;
        default: f3 = F3_HU;
      endcase
      a = $urandom;
      if (f3[1:0] == 2'b01) a[0] = 1'b0;
      if (f3[1:0] == 2'b10) a[1:0] = 2'b00;
      case (kind)
        0: issue(1, 1, 2'b00, 0, f3, a, $urandom, 5'($urandom),
                 $urandom, 0, 0);
        1: issue(1, 1, 2'b01, 0, f3, a, 0, 5'($urandom), $urandom,
                 $urandom_range(0, 3), $urandom);
        2: issue(1, 0, 2'b00, 1, f3, a, $urandom, 5'($urandom),
                 $urandom, $urandom_range(0, 3), 0);
        3: issue(1, 1, 2'b10, 0, f3, a, 0, 5'($urandom), $urandom, 0, 0);
        default: idle();
      endcase
    end
    idle();

`ifdef MEM_TIMEOUT_EN
    // Memory never answers: forced completion with zero load data
    issue(1, 1, 2'b01, 0, F3_W, 32'h500, 0, 5'd12, 0, 100,
          32'h1234_5678);
    chk("to_wd3_lit", WD3, 32'h0);
    chk("to_we3_lit", {31'b0, WE3}, 32'h1);
    idle();
`endif

    idle();
    idle();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
